// File: rtl/l1ca_search_sched.sv
`default_nettype none
// ============================================================================
// Module   : l1ca_search_sched
// Desc     : Walks an SV mask, runs one acquisition per enabled SV and emits
//            one thresholded result record per SV over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module l1ca_search_sched #(
  parameter int CAPTURE_LEN  = 19200,
  parameter int WAIT_TIMEOUT = 1048575
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        go,
  input  logic        abort,
  input  logic [31:0] sv_mask,
  input  logic [31:0] threshold,
  output logic        srch_start,
  output logic [4:0]  srch_sv,
  input  logic        srch_busy,
  input  logic [31:0] srch_acc,
  input  logic [11:0] srch_code,
  input  logic [4:0]  srch_dop,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_sv,
  output logic [31:0] res_acc,
  output logic [11:0] res_code,
  output logic [4:0]  res_dop,
  output logic        res_found,
  output logic        res_timeout,
  output logic        busy,
  output logic        done,
  output logic [5:0]  det_count
);

  localparam int c_CAP_W  = $clog2(CAPTURE_LEN + 1);
  localparam int c_WAIT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [c_CAP_W-1:0]  c_CAP_LAST  = c_CAP_W'(CAPTURE_LEN - 1);
  localparam logic [c_CAP_W-1:0]  c_CAP_MAX   = c_CAP_W'(CAPTURE_LEN);
  localparam logic [c_CAP_W-1:0]  c_CAP_ONE   = c_CAP_W'(1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_TIMEOUT - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(WAIT_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_SKIP = c_WAIT_W'(2);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_WAIT    = 3'd2,
    S_EMIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [c_CAP_W-1:0]    r_cap_cnt;
  logic [c_WAIT_W-1:0]   r_wait_cnt;
  logic [31:0]           r_mask;
  logic [31:0]           r_thr;
  logic                  w_accept;
  logic                  w_abort;
  logic                  w_cap_last;
  logic                  w_wait_idle;
  logic                  w_wait_expired;
  logic                  w_xfer;
  logic [31:0]           w_above;
  logic [5:0]            w_first;
  logic [5:0]            w_next;

  // Index of the lowest set bit; 32 means no bit set.
  function automatic logic [5:0] f_lowest(input logic [31:0] v);
    logic [5:0] idx;
    idx = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  assign w_accept       = (r_state == S_IDLE) && go && (sv_mask != 32'd0) && !srch_busy;
  assign w_abort        = abort && (r_state != S_IDLE);
  assign w_cap_last     = (r_cap_cnt == c_CAP_LAST);
  assign w_wait_idle    = (r_wait_cnt >= c_WAIT_SKIP) && !srch_busy;
  assign w_wait_expired = (r_wait_cnt == c_WAIT_LAST);
  assign w_xfer         = res_valid && res_ready;
  assign w_above        = r_mask & (32'hFFFF_FFFF << ({1'b0, srch_sv} + 6'd1));
  assign w_first        = f_lowest(sv_mask);
  assign w_next         = f_lowest(w_above);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_abort) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_accept) w_state_nx = S_CAPTURE;
        S_CAPTURE: if (w_cap_last) w_state_nx = S_WAIT;
        S_WAIT:    if (w_wait_idle || w_wait_expired) w_state_nx = S_EMIT;
        S_EMIT:    if (w_xfer) w_state_nx = w_next[5] ? S_DONE : S_CAPTURE;
        S_DONE:    w_state_nx = S_IDLE;
        default:   w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      srch_start  <= 1'b0;
      srch_sv     <= 5'd0;
      res_valid   <= 1'b0;
      res_sv      <= 5'd0;
      res_acc     <= 32'd0;
      res_code    <= 12'd0;
      res_dop     <= 5'd0;
      res_found   <= 1'b0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      det_count   <= 6'd0;
      r_mask      <= 32'd0;
      r_thr       <= 32'd0;
      r_cap_cnt   <= '0;
      r_wait_cnt  <= '0;
    end else begin
      // Control outputs are registered copies of the next-state decode.
      srch_start <= (w_state_nx == S_CAPTURE);
      res_valid  <= (w_state_nx == S_EMIT);
      busy       <= (w_state_nx != S_IDLE);
      done       <= (w_state_nx == S_DONE);

      if (r_state != S_CAPTURE)     r_cap_cnt <= '0;
      else if (r_cap_cnt != c_CAP_MAX) r_cap_cnt <= r_cap_cnt + c_CAP_ONE;

      if (r_state != S_WAIT)          r_wait_cnt <= '0;
      else if (r_wait_cnt != c_WAIT_MAX) r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;

      if (w_accept) begin
        r_mask    <= sv_mask;
        r_thr     <= threshold;
        det_count <= 6'd0;
        srch_sv   <= w_first[4:0];
      end

      if (!w_abort && (r_state == S_WAIT)) begin
        if (w_wait_idle) begin
          res_sv      <= srch_sv;
          res_acc     <= srch_acc;
          res_code    <= srch_code;
          res_dop     <= srch_dop;
          res_timeout <= 1'b0;
          res_found   <= (srch_acc >= r_thr);
        end else if (w_wait_expired) begin
          res_sv      <= srch_sv;
          res_acc     <= 32'd0;
          res_code    <= 12'd0;
          res_dop     <= 5'd0;
          res_timeout <= 1'b1;
          res_found   <= 1'b0;
        end
      end

      if (!w_abort && (r_state == S_EMIT) && w_xfer) begin
        if (res_found) det_count <= det_count + 6'd1;
        if (!w_next[5]) srch_sv <= w_next[4:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1ca_search_sched.sv
`default_nettype none
// Bench for l1ca_search_sched: engine model, directed scan table, hand-written
// abort/reset sequences and randomized scans against a record-list model.
module tb_l1ca_search_sched;

  localparam int CAP = 8;
  localparam int WTO = 50;

  logic        clk;
  logic        nrst;
  logic        go;
  logic        abort;
  logic [31:0] sv_mask;
  logic [31:0] threshold;
  logic        srch_start;
  logic [4:0]  srch_sv;
  logic        srch_busy;
  logic [31:0] srch_acc;
  logic [11:0] srch_code;
  logic [4:0]  srch_dop;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_sv;
  logic [31:0] res_acc;
  logic [11:0] res_code;
  logic [4:0]  res_dop;
  logic        res_found;
  logic        res_timeout;
  logic        busy;
  logic        done;
  logic [5:0]  det_count;

  l1ca_search_sched #(.CAPTURE_LEN(CAP), .WAIT_TIMEOUT(WTO)) dut (
    .clk(clk), .nrst(nrst), .go(go), .abort(abort),
    .sv_mask(sv_mask), .threshold(threshold),
    .srch_start(srch_start), .srch_sv(srch_sv), .srch_busy(srch_busy),
    .srch_acc(srch_acc), .srch_code(srch_code), .srch_dop(srch_dop),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sv(res_sv), .res_acc(res_acc), .res_code(res_code), .res_dop(res_dop),
    .res_found(res_found), .res_timeout(res_timeout),
    .busy(busy), .done(done), .det_count(det_count)
  );

  always #5 clk = ~clk;

  // Engine model: busy for busy_len cycles after start rises, or forever when stuck.
  logic [31:0] eng_acc  [32];
  logic [11:0] eng_code [32];
  logic [4:0]  eng_dop  [32];
  logic        prev_start;
  logic        stuck;
  int          eng_cnt;
  int          busy_len;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_start <= 1'b0;
      eng_cnt    <= 0;
    end else begin
      prev_start <= srch_start;
      if (srch_start && !prev_start) eng_cnt <= busy_len;
      else if (eng_cnt != 0 && !stuck) eng_cnt <= eng_cnt - 1;
    end
  end

  assign srch_busy = (eng_cnt != 0);
  assign srch_acc  = eng_acc[srch_sv];
  assign srch_code = eng_code[srch_sv];
  assign srch_dop  = eng_dop[srch_sv];

  typedef struct packed {
    logic [4:0]  sv;
    logic [31:0] acc;
    logic [11:0] code;
    logic [4:0]  dop;
    logic        found;
    logic        to;
  } rec_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] thr;
    int          stall;
    bit          stk;
    int          exp_det;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  rec_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected record list: one per enabled SV in ascending order.
  task automatic model(input logic [31:0] mask, input logic [31:0] thr, input bit stk, output int ndet);
    rec_t r;
    exp_q.delete();
    ndet = 0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) begin
        r.sv    = 5'(i);
        r.to    = stk;
        r.acc   = stk ? 32'd0 : eng_acc[i];
        r.code  = stk ? 12'd0 : eng_code[i];
        r.dop   = stk ? 5'd0  : eng_dop[i];
        r.found = !stk && (eng_acc[i] >= thr);
        if (r.found) ndet++;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic wait_eng_idle();
    int k;
    k = 0;
    while (srch_busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("eng_idle_bound", 64'(srch_busy), 64'd0);
  endtask

  task automatic run_scan(input logic [31:0] mask, input logic [31:0] thr, input int stall,
                          input bit stk, input int exp_det, input string tag);
    int   ndet, idx, run_len, stall_left, cyc;
    bit   in_rec, after_xfer, seen_done;
    rec_t snap, cur;
    model(mask, thr, stk, ndet);
    wait_eng_idle();
    stuck = stk;
    sv_mask = mask;
    threshold = thr;
    res_ready = (stall == 0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk({tag, "/start_after_go"}, 64'(srch_start), 64'd1);
    chk({tag, "/det_cleared"}, 64'(det_count), 64'd0);
    idx = 0; run_len = 0; stall_left = 0; cyc = 0;
    in_rec = 0; after_xfer = 0; seen_done = 0;
    snap = '0;
    while (!seen_done && cyc < 6000) begin
      cur = {res_sv, res_acc, res_code, res_dop, res_found, res_timeout};
      if (after_xfer) begin
        after_xfer = 0;
        if (idx < exp_q.size()) chk({tag, "/next_start"}, 64'(srch_start), 64'd1);
        else                    chk({tag, "/done_after_last"}, 64'(done), 64'd1);
      end
      if (srch_start) begin
        run_len++;
      end else if (run_len > 0) begin
        chk({tag, "/start_len"}, 64'(run_len), 64'(CAP));
        if (idx < exp_q.size()) chk({tag, "/start_sv"}, 64'(srch_sv), 64'(exp_q[idx].sv));
        else                    chk({tag, "/extra_run"}, 64'(idx), 64'(exp_q.size()));
        run_len = 0;
      end
      if (res_valid) begin
        if (!in_rec) begin
          in_rec = 1;
          snap = cur;
          stall_left = stall;
        end else begin
          chk({tag, "/hold"}, 64'({cur, srch_start}), 64'({snap, 1'b0}));
        end
        if (stall_left == 0) begin
          res_ready = 1'b1;
          if (idx < exp_q.size()) chk({tag, "/record"}, 64'(cur), 64'(exp_q[idx]));
          else                    chk({tag, "/extra_record"}, 64'(idx), 64'(exp_q.size()));
          idx++;
          in_rec = 0;
          after_xfer = 1;
        end else begin
          res_ready = 1'b0;
          stall_left--;
        end
      end
      if (done) seen_done = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "/done_seen"}, 64'(seen_done), 64'd1);
    chk({tag, "/rec_count"}, 64'(idx), 64'(exp_q.size()));
    chk({tag, "/det_count"}, 64'(det_count), 64'((exp_det < 0) ? ndet : exp_det));
    @(negedge clk);
    chk({tag, "/done_one_cycle"}, 64'({done, busy}), 64'd0);
    stuck = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bad, nd;
    logic [31:0] m;
    clk = 0; nrst = 0; go = 0; abort = 0; sv_mask = 0; threshold = 0;
    res_ready = 0; stuck = 0; busy_len = 20;
    for (int i = 0; i < 32; i++) begin
      eng_acc[i]  = 32'(i * 37 + 11);
      eng_code[i] = 12'(i * 101 + 3);
      eng_dop[i]  = 5'(i + 1);
    end
    eng_acc[12] = 250; eng_code[12] = 517; eng_dop[12] = 9;
    eng_acc[0] = 50; eng_acc[2] = 150; eng_acc[31] = 200;

    vecs[0] = '{32'h0000_1000, 32'd100, 0,  1'b0, 1};
    vecs[1] = '{32'h8000_0005, 32'd150, 0,  1'b0, 2};
    vecs[2] = '{32'h8000_0005, 32'd150, 10, 1'b0, 2};
    vecs[3] = '{32'h0000_0006, 32'd0,   0,  1'b1, 0};
    vecs[4] = '{32'h4000_0001, 32'd0,   3,  1'b1, 0};

    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({srch_start, srch_sv, res_valid, busy, done, det_count}), 64'd0);
    chk("reset_rec", 64'({res_sv, res_acc, res_code, res_dop, res_found, res_timeout}), 64'd0);
    nrst = 1;
    @(negedge clk);

    // Empty mask is ignored
    sv_mask = 0; threshold = 5; go = 1;
    @(negedge clk);
    go = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy || srch_start) bad++;
      @(negedge clk);
    end
    chk("mask0_ignored", 64'(bad), 64'd0);

    for (int v = 0; v < 5; v++)
      run_scan(vecs[v].mask, vecs[v].thr, vecs[v].stall, vecs[v].stk, vecs[v].exp_det,
               $sformatf("vec%0d", v));

    // Abort during capture of the second SV
    wait_eng_idle();
    busy_len = 20;
    sv_mask = 32'h8000_0005; threshold = 40; res_ready = 1; go = 1;
    @(negedge clk);
    go = 0;
    k = 0;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort/first_rec", 64'(res_valid), 64'd1);
    repeat (3) @(negedge clk);
    chk("abort/pre", 64'({srch_start, srch_sv}), 64'({1'b1, 5'd2}));
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort/stop", 64'({srch_start, busy, res_valid, done}), 64'd0);
    chk("abort/det_frozen", 64'(det_count), 64'd1);
    chk("abort/eng_still_busy", 64'(srch_busy), 64'd1);
    go = 1;
    @(negedge clk);
    go = 0;
    chk("abort/go_while_eng_busy", 64'({busy, srch_start}), 64'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (res_valid || done || srch_start || busy || det_count != 6'd1) bad++;
      @(negedge clk);
    end
    chk("abort/quiet", 64'(bad), 64'd0);
    run_scan(32'h8000_0005, 32'd150, 0, 1'b0, 2, "post_abort");

    // Asynchronous reset mid-scan, between clock edges
    busy_len = 12;
    sv_mask = 32'h0000_0030; threshold = 0; res_ready = 1; go = 1;
    @(negedge clk);
    go = 0;
    k = 0;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("areset/first_rec", 64'({res_valid, res_sv}), 64'({1'b1, 5'd4}));
    @(negedge clk);
    chk("areset/pre", 64'({srch_start, srch_sv, det_count}), 64'({1'b1, 5'd5, 6'd1}));
    #2 nrst = 0;
    #1;
    chk("areset/ctrl", 64'({srch_start, srch_sv, res_valid, busy, done, det_count}), 64'd0);
    chk("areset/rec", 64'({res_sv, res_acc, res_code, res_dop, res_found, res_timeout}), 64'd0);
    @(negedge clk);
    nrst = 1;
    @(negedge clk);

    // Randomized scans against the record-list model
    for (int r = 0; r < 12; r++) begin
      wait_eng_idle();
      for (int i = 0; i < 32; i++) begin
        eng_acc[i]  = 32'($urandom_range(0, 1000));
        eng_code[i] = 12'($urandom);
        eng_dop[i]  = 5'($urandom);
      end
      busy_len = int'($urandom_range(3, 30));
      m = $urandom & $urandom & $urandom;
      if (m == 32'd0) m = 32'd1 << $urandom_range(0, 31);
      model(m, 32'($urandom_range(0, 1000)), 1'b0, nd);
      run_scan(m, 32'($urandom_range(0, 1000)), int'($urandom_range(0, 3)), 1'b0, -1,
               $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
